stream_mux_n_1: RTL and testbench
=================================

Name: stream_mux_n_1

Overview:
- Parametrised successor to the fixed 2/4/8-input combinational muxes.
- Selects one of CHANNELS valid/ready input streams of width N and forwards it through one registered output stage.
- Selection is either an explicit select or round-robin arbitration.
- Sits between multiple producers (e.g. register-file read ports, memory response queues) and a single consumer.

Parameters:
- N, 32, data width per channel in bits.
- CHANNELS, 8, number of input streams; legal range 2..32, need not be a power of two.
- SEL_W, $clog2(CHANNELS), width of select and out_channel; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  CHANNELS*N  flattened inputs; channel k occupies bits [k*N +: N].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- select  input  SEL_W  channel index used when mode=0.
- out_data  output  N  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.
- out_channel  output  SEL_W  registered index of the channel that produced out_data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_channel=0, round-robin pointer rr_ptr=0.
- Output stage is a single register slot.
  - load_en = !out_valid || out_ready.
  - Full throughput: one beat per cycle when out_ready stays high.
- Grant (combinational):
  - mode=0: grant to channel select if select<CHANNELS and in_valid[select]; otherwise no grant.
  - mode=1: grant to the first k with in_valid[k], scanning rr_ptr, rr_ptr+1, … modulo CHANNELS; no grant if all in_valid=0.
- in_ready[k]=1 only when load_en=1, a grant exists, and the granted channel is k. All other bits are 0, and at most one bit is set.
- Transfer on a channel = in_valid[k] && in_ready[k]. On transfer at edge t:
  - out_data=in_data[k], out_channel=k, out_valid=1 from t onward.
  - Latency is exactly 1 cycle.
- rr_ptr update (mode=1 only): on a transfer from channel k, rr_ptr <= (k==CHANNELS-1) ? 0 : k+1. rr_ptr is unchanged otherwise and in mode=0.
- Output handshake: if out_ready=1 and there is no new transfer, out_valid <= 0. While out_valid=1 and out_ready=0, out_data, out_valid and out_channel hold stable.
- Simultaneous consume+load: out_valid stays 1, the new beat is loaded, no bubble.
- Changing mode or select with a beat pending affects only the next grant; the registered beat is untouched.
- Reset mid-stream drops the pending output beat; rr_ptr returns to 0.

Optional Feature:
- Macro STREAM_MUX_PACKET_LOCK_EN.
- Defined:
  - Adds input in_last [CHANNELS] and output out_last (1 bit, registered, reset 0).
  - After a transfer with in_last[k]=0, the grant locks to channel k, ignoring mode, select and rr_ptr, until a transfer with in_last[k]=1.
  - rr_ptr advances only on that last beat.
  - Reset clears the lock.
- Undefined: no extra ports; every beat is arbitrated independently.

Test Plan:
1. Fixed mode: mode=0, select swept 0..7, random in_data, all in_valid=1, out_ready=1 -> each cycle out_data=in_data[select] one cycle later, out_channel=select, only in_ready[select]=1.
2. Round-robin fairness: mode=1, in_valid=8'b1010_0101, out_ready=1 for 8 cycles -> out_channel sequence 0,2,5,7,0,2,5,7.
3. Backpressure: out_valid=1 holding 0xDEADBEEF, out_ready=0 for 5 cycles -> out_data stable, in_ready all 0. Then out_ready=1 with a new valid input -> new beat next cycle, no bubble.
4. Out-of-range select: CHANNELS=6, mode=0, select=7, all valid -> in_ready=0, out_valid stays 0.
5. Reset mid-operation: assert rst_n=0 asynchronously with out_valid=1 and rr_ptr=3 -> out_valid/out_data/out_channel go 0 immediately. After release in mode=1 with all valid, the first grant is channel 0.
6. With STREAM_MUX_PACKET_LOCK_EN: mode=1, channel 1 sends 3 beats with in_last on the 3rd while channel 0 is valid -> out_channel 1,1,1 with out_last only on the third beat, then channel 2 or the next valid channel after 1.

Source files
------------

// File: rtl/stream_mux_n_1.sv
// CHANNELS-to-1 valid/ready stream mux with fixed-select or round-robin grant and one registered output slot.
// Optional packet lock (macro STREAM_MUX_PACKET_LOCK_EN) adds in_last/out_last and holds the grant until a last beat.
module stream_mux_n_1 #(
  parameter int N        = 32,
  parameter int CHANNELS = 8,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS*N-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  output logic [CHANNELS-1:0]   in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      select,
`ifdef STREAM_MUX_PACKET_LOCK_EN
  input  logic [CHANNELS-1:0]   in_last,
  output logic                  out_last,
`endif
  output logic [N-1:0]          out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_channel
);

  logic             load_en;
  logic             grant_ok;
  logic             xfer;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_next;
  logic [N-1:0]     sel_data;
  logic             locked;
  logic [SEL_W-1:0] lock_ch;
  logic             beat_ends;
  int unsigned      rr_idx;

`ifdef STREAM_MUX_PACKET_LOCK_EN
  typedef enum logic {LOCK_IDLE, LOCK_HELD} lock_state_e;

  lock_state_e      lock_state;
  lock_state_e      lock_state_next;
  logic [SEL_W-1:0] lock_ch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state <= LOCK_IDLE;
      lock_ch_q  <= '0;
      out_last   <= 1'b0;
    end else begin
      lock_state <= lock_state_next;
      if (xfer) begin
        lock_ch_q <= grant_idx;
        out_last  <= in_last[grant_idx];
      end
    end
  end

  always_comb begin
    lock_state_next = lock_state;
    if (xfer) lock_state_next = in_last[grant_idx] ? LOCK_IDLE : LOCK_HELD;
  end

  always_comb begin
    locked    = (lock_state == LOCK_HELD);
    lock_ch   = lock_ch_q;
    beat_ends = in_last[grant_idx];
  end
`else
  always_comb begin
    locked    = 1'b0;
    lock_ch   = '0;
    beat_ends = 1'b1;
  end
`endif

  assign load_en = !out_valid || out_ready;
  assign xfer    = load_en && grant_ok;

  // Round-robin scans rr_ptr upward with wrap at CHANNELS, which need not be a power of two.
  always_comb begin
    grant_ok  = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    if (locked) begin
      grant_ok  = in_valid[lock_ch];
      grant_idx = lock_ch;
    end else if (!mode) begin
      if (int'(select) < CHANNELS) begin
        grant_ok  = in_valid[select];
        grant_idx = select;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        rr_idx = 32'(rr_ptr) + i;
        if (rr_idx >= CHANNELS) rr_idx = rr_idx - CHANNELS;
        if (!grant_ok && in_valid[rr_idx[SEL_W-1:0]]) begin
          grant_ok  = 1'b1;
          grant_idx = rr_idx[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (grant_idx == k[SEL_W-1:0]) begin
        in_ready[k] = xfer;
        sel_data    = in_data[k*N +: N];
      end
    end
  end

  assign rr_next = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      rr_ptr      <= '0;
    end else begin
      if (load_en) out_valid <= xfer;
      if (xfer) begin
        out_data    <= sel_data;
        out_channel <= grant_idx;
      end
      if (xfer && mode && beat_ends) rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_stream_mux_n_1.sv
// Bench for stream_mux_n_1: directed steps plus random traffic against a queue-free arithmetic reference model.
// Packet-lock checks are compiled in when STREAM_MUX_PACKET_LOCK_EN is defined.
module tb_stream_mux_n_1;
  localparam int N  = 32;
  localparam int C  = 8;
  localparam int C6 = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [C*N-1:0] in_data;
  logic [C-1:0]   in_valid;
  logic [C-1:0]   in_ready;
  logic           mode;
  logic [2:0]     select;
  logic [N-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     out_channel;
`ifdef STREAM_MUX_PACKET_LOCK_EN
  logic [C-1:0]   in_last;
  logic           out_last;
  logic [C6-1:0]  in_last6;
  logic           out_last6;
`endif

  logic [C6*N-1:0] in_data6;
  logic [C6-1:0]   in_valid6;
  logic [C6-1:0]   in_ready6;
  logic            mode6;
  logic [2:0]      select6;
  logic [N-1:0]    out_data6;
  logic            out_valid6;
  logic            out_ready6;
  logic [2:0]      out_channel6;

  stream_mux_n_1 #(.N(N), .CHANNELS(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .select(select),
`ifdef STREAM_MUX_PACKET_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel)
  );

  stream_mux_n_1 #(.N(N), .CHANNELS(C6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
    .mode(mode6), .select(select6),
`ifdef STREAM_MUX_PACKET_LOCK_EN
    .in_last(in_last6), .out_last(out_last6),
`endif
    .out_data(out_data6), .out_valid(out_valid6), .out_ready(out_ready6), .out_channel(out_channel6)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state for the 8-channel instance.
  bit           m_valid;
  logic [N-1:0] m_data;
  int           m_ch;
  int           m_rr;
  bit           m_lock;
  int           m_lock_ch;
  bit           m_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_ch = 0; m_rr = 0; m_lock = 0; m_lock_ch = 0; m_last = 0;
  endtask

  task automatic model_grant(output bit gok, output int g);
    gok = 0;
    g   = 0;
    if (m_lock) begin
      gok = in_valid[m_lock_ch];
      g   = m_lock_ch;
    end else if (mode == 1'b0) begin
      if (int'(select) < C && in_valid[select]) begin
        gok = 1;
        g   = int'(select);
      end
    end else begin
      for (int off = 0; off < C; off++) begin
        int k;
        k = (m_rr + off) % C;
        if (!gok && in_valid[k]) begin
          gok = 1;
          g   = k;
        end
      end
    end
  endtask

  // One clock: check in_ready before the edge, advance the model on the edge, check outputs just after.
  task automatic cycle(input string tag);
    bit           gok;
    int           g;
    bit           le;
    logic [C-1:0] er;
    #1;
    le = !m_valid || out_ready;
    model_grant(gok, g);
    er = (le && gok) ? (C'(1) << g) : '0;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(er));
    @(posedge clk);
    if (le) begin
      m_valid = gok;
      if (gok) begin
        m_data = in_data[g*N +: N];
        m_ch   = g;
`ifdef STREAM_MUX_PACKET_LOCK_EN
        m_last    = in_last[g];
        m_lock    = !in_last[g];
        m_lock_ch = g;
        if (mode && in_last[g]) m_rr = (g + 1) % C;
`else
        if (mode) m_rr = (g + 1) % C;
`endif
      end
    end
    #1;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".out_data"}, 64'(out_data), 64'(m_data));
    chk({tag, ".out_channel"}, 64'(out_channel), 64'(m_ch));
`ifdef STREAM_MUX_PACKET_LOCK_EN
    chk({tag, ".out_last"}, 64'(out_last), 64'(m_last));
`endif
  endtask

  task automatic rand_data();
    for (int k = 0; k < C; k++) in_data[k*N +: N] = $urandom;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #3 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rr_seq [8];
    rr_seq = '{0, 2, 5, 7, 0, 2, 5, 7};

    rst_n = 1'b0;
    in_data = '0; in_valid = '0; mode = 1'b0; select = '0; out_ready = 1'b0;
    in_data6 = '0; in_valid6 = '0; mode6 = 1'b0; select6 = '0; out_ready6 = 1'b0;
`ifdef STREAM_MUX_PACKET_LOCK_EN
    in_last = '1; in_last6 = '1;
`endif
    model_reset();
    #12;
    chk("reset.out_valid", 64'(out_valid), 64'(0));
    chk("reset.out_data", 64'(out_data), 64'(0));
    chk("reset.out_channel", 64'(out_channel), 64'(0));
    chk("reset.in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b1;

    // Fixed select sweep.
    mode = 1'b0; in_valid = '1; out_ready = 1'b1;
    for (int s = 0; s < C; s++) begin
      rand_data();
      select = 3'(s);
      cycle("fixed");
      chk("fixed.chan_lit", 64'(out_channel), 64'(s));
    end

    // Round-robin fairness over a sparse valid pattern.
    mode = 1'b1; in_valid = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      cycle("rr");
      chk("rr.seq_lit", 64'(out_channel), 64'(rr_seq[i]));
    end

    // Backpressure: park 0xDEADBEEF, stall, then consume and reload in the same cycle.
    mode = 1'b0; select = 3'd3; in_valid = 8'b0000_1000;
    in_data[3*N +: N] = 32'hDEAD_BEEF;
    cycle("bp_load");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      in_valid = '1;
      cycle("bp_hold");
      chk("bp_hold.data_lit", 64'(out_data), 64'h0000_0000_DEAD_BEEF);
    end
    out_ready = 1'b1; in_data[3*N +: N] = 32'h1234_5678;
    cycle("bp_release");
    chk("bp_release.data_lit", 64'(out_data), 64'h0000_0000_1234_5678);
    chk("bp_release.valid_lit", 64'(out_valid), 64'(1));

    // Out-of-range select on the 6-channel instance, then its top legal channel.
    in_valid6 = '1; mode6 = 1'b0; out_ready6 = 1'b1;
    for (int k = 0; k < C6; k++) in_data6[k*N +: N] = $urandom;
    for (int s = 6; s < 8; s++) begin
      select6 = 3'(s);
      #1 chk("oor.in_ready6", 64'(in_ready6), 64'(0));
      @(posedge clk);
      #1 chk("oor.out_valid6", 64'(out_valid6), 64'(0));
    end
    select6 = 3'd5;
    #1 chk("ch5.in_ready6", 64'(in_ready6), 64'(6'b10_0000));
    @(posedge clk);
    #1;
    chk("ch5.out_valid6", 64'(out_valid6), 64'(1));
    chk("ch5.out_channel6", 64'(out_channel6), 64'(5));
    chk("ch5.out_data6", 64'(out_data6), 64'(in_data6[5*N +: N]));

`ifdef STREAM_MUX_PACKET_LOCK_EN
    // Packet lock: 3-beat packet on channel 1 with channel 0 also requesting.
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 8'b0000_0001; in_last = '1;
    cycle("lock_pre");
    in_valid = 8'b0000_0111; in_last = 8'b1111_1101;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      if (i == 2) in_last = '1;
      cycle("lock_pkt");
      chk("lock_pkt.chan_lit", 64'(out_channel), 64'(1));
      chk("lock_pkt.last_lit", 64'(out_last), 64'(i == 2));
    end
    cycle("lock_after");
    chk("lock_after.chan_lit", 64'(out_channel), 64'(2));
`endif

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      rand_data();
      in_valid  = C'($urandom);
      mode      = 1'($urandom_range(0, 1));
      select    = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_PACKET_LOCK_EN
      in_last   = C'($urandom);
`endif
      cycle("rand");
    end

    // Asynchronous reset mid-stream with rr_ptr at 3 and a beat parked.
    do_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 8'b0000_0100;
`ifdef STREAM_MUX_PACKET_LOCK_EN
    in_last = '1;
`endif
    rand_data();
    cycle("pre_rst");
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst.out_valid", 64'(out_valid), 64'(0));
    chk("async_rst.out_data", 64'(out_data), 64'(0));
    chk("async_rst.out_channel", 64'(out_channel), 64'(0));
    #2 rst_n = 1'b1;
    in_valid = '1; out_ready = 1'b1;
    rand_data();
    cycle("post_rst");
    chk("post_rst.chan_lit", 64'(out_channel), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
